// File: rtl/conv553_feeder.sv
// conv553_feeder: raster pixel stream to 5x5x3 window column feeder.
// Four-row line buffers per channel; one column per accepted beat.
module conv553_feeder #(
  parameter int BIT_WIDTH = 8,
  parameter int IMG_W     = 14,
  parameter int IMG_H     = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3*BIT_WIDTH-1:0]      in_data,
  output logic                        en,
  output logic signed [BIT_WIDTH-1:0] in01,
  output logic signed [BIT_WIDTH-1:0] in02,
  output logic signed [BIT_WIDTH-1:0] in03,
  output logic signed [BIT_WIDTH-1:0] in04,
  output logic signed [BIT_WIDTH-1:0] in05,
  output logic signed [BIT_WIDTH-1:0] in11,
  output logic signed [BIT_WIDTH-1:0] in12,
  output logic signed [BIT_WIDTH-1:0] in13,
  output logic signed [BIT_WIDTH-1:0] in14,
  output logic signed [BIT_WIDTH-1:0] in15,
  output logic signed [BIT_WIDTH-1:0] in21,
  output logic signed [BIT_WIDTH-1:0] in22,
  output logic signed [BIT_WIDTH-1:0] in23,
  output logic signed [BIT_WIDTH-1:0] in24,
  output logic signed [BIT_WIDTH-1:0] in25,
  output logic                        win_valid,
  output logic [7:0]                  out_row,
  output logic [7:0]                  out_col,
  output logic                        frame_done
);

  localparam int BW = BIT_WIDTH;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(4);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILL = RW'(3);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  // slot holds row mod 4: the ring position of the oldest stored row
  logic [1:0]    slot;

  logic [3*BW-1:0] lb [4][IMG_W];

  logic            acc;
  logic            col_end;
  logic            row_end;
  logic [3*BW-1:0] rd0;
  logic [3*BW-1:0] rd1;
  logic [3*BW-1:0] rd2;
  logic [3*BW-1:0] rd3;

  assign acc     = in_valid & in_ready;
  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);

  // rows r-4 .. r-1 sit at slot, slot+1, slot+2, slot+3
  assign rd0 = lb[slot][col];
  assign rd1 = lb[slot + 2'd1][col];
  assign rd2 = lb[slot + 2'd2][col];
  assign rd3 = lb[slot + 2'd3][col];

  // line buffer: accepted pixel replaces the row-(r-4) entry after its read
  always_ff @(posedge clk) begin
    if (acc) begin
      lb[slot][col] <= in_data;
    end
  end

  // control FSM, position counters and registered window column
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      slot       <= '0;
      in_ready   <= 1'b0;
      en         <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      in01       <= '0;
      in02       <= '0;
      in03       <= '0;
      in04       <= '0;
      in05       <= '0;
      in11       <= '0;
      in12       <= '0;
      in13       <= '0;
      in14       <= '0;
      in15       <= '0;
      in21       <= '0;
      in22       <= '0;
      in23       <= '0;
      in24       <= '0;
      in25       <= '0;
    end else begin
      en         <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;

      if (acc) begin
        if (col_end) begin
          col  <= '0;
          slot <= slot + 2'd1;
          row  <= row_end ? '0 : row + RW'(1);
        end else begin
          col  <= col + CW'(1);
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            in_ready <= 1'b1;
            col      <= '0;
            row      <= '0;
            slot     <= '0;
          end
        end

        FILL: begin
          if (acc && row == ROW_FILL && col_end) begin
            state <= STREAM;
          end
        end

        STREAM: begin
          if (acc) begin
            en        <= 1'b1;
            win_valid <= (col >= COL_WIN);
            out_row   <= 8'(row) - 8'd4;
            out_col   <= 8'(col) - 8'd4;

            in01 <= rd0[BW-1:0];
            in02 <= rd1[BW-1:0];
            in03 <= rd2[BW-1:0];
            in04 <= rd3[BW-1:0];
            in05 <= in_data[BW-1:0];

            in11 <= rd0[2*BW-1:BW];
            in12 <= rd1[2*BW-1:BW];
            in13 <= rd2[2*BW-1:BW];
            in14 <= rd3[2*BW-1:BW];
            in15 <= in_data[2*BW-1:BW];

            in21 <= rd0[3*BW-1:2*BW];
            in22 <= rd1[3*BW-1:2*BW];
            in23 <= rd2[3*BW-1:2*BW];
            in24 <= rd3[3*BW-1:2*BW];
            in25 <= in_data[3*BW-1:2*BW];

            if (row_end && col_end) begin
              state      <= DONE;
              in_ready   <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv553_feeder.sv
// tb_conv553_feeder: randomized frames against a row/column window model.
// Model tracks beats and expected columns; DUT is only compared.
module tb_conv553_feeder;

  localparam int BW = 8;
  localparam int W  = 14;
  localparam int H  = 14;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic in_valid;
  logic in_ready;
  logic [3*BW-1:0] in_data;
  logic en;
  logic signed [BW-1:0] in01, in02, in03, in04, in05;
  logic signed [BW-1:0] in11, in12, in13, in14, in15;
  logic signed [BW-1:0] in21, in22, in23, in24, in25;
  logic win_valid;
  logic [7:0] out_row;
  logic [7:0] out_col;
  logic frame_done;

  always #5 clk = ~clk;

  conv553_feeder #(
    .BIT_WIDTH(BW),
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .en(en),
    .in01(in01), .in02(in02), .in03(in03), .in04(in04), .in05(in05),
    .in11(in11), .in12(in12), .in13(in13), .in14(in14), .in15(in15),
    .in21(in21), .in22(in22), .in23(in23), .in24(in24), .in25(in25),
    .win_valid(win_valid),
    .out_row(out_row),
    .out_col(out_col),
    .frame_done(frame_done)
  );

  logic [7:0] got [3][5];
  assign got[0][0] = in01;
  assign got[0][1] = in02;
  assign got[0][2] = in03;
  assign got[0][3] = in04;
  assign got[0][4] = in05;
  assign got[1][0] = in11;
  assign got[1][1] = in12;
  assign got[1][2] = in13;
  assign got[1][3] = in14;
  assign got[1][4] = in15;
  assign got[2][0] = in21;
  assign got[2][1] = in22;
  assign got[2][2] = in23;
  assign got[2][3] = in24;
  assign got[2][4] = in25;

  int checks   = 0;
  int failures = 0;

  int img [H][W][3];

  bit busy;
  int nbeat;
  bit exp_en;
  bit exp_wv;
  bit exp_fd;
  int exp_col [3][5];
  int exp_orow;
  int exp_ocol;
  bit spec_img;
  bit first_seen;
  int en_cnt;
  int wv_cnt;

  task automatic chk(string tag, logic [31:0] g, logic [31:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, g, e);
    end
  endtask

  task automatic fill_img(bit formula);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int x = 0; x < 3; x++)
          img[r][c][x] = formula ? (r * W + c + x) % 256
                                 : int'($urandom_range(255));
  endtask

  task automatic clear_model();
    busy     = 1'b0;
    nbeat    = 0;
    exp_en   = 1'b0;
    exp_wv   = 1'b0;
    exp_fd   = 1'b0;
    exp_orow = 0;
    exp_ocol = 0;
    for (int x = 0; x < 3; x++)
      for (int j = 0; j < 5; j++)
        exp_col[x][j] = 0;
  endtask

  task automatic check_outs(bit in_rst);
    chk("in_ready", in_ready, busy);
    chk("en", en, exp_en);
    chk("frame_done", frame_done, exp_fd);
    chk("win_valid", win_valid, exp_wv);
    for (int x = 0; x < 3; x++)
      for (int j = 0; j < 5; j++)
        chk($sformatf("in%0d%0d", x, j + 1), got[x][j], exp_col[x][j]);
    if (exp_wv || in_rst) begin
      chk("out_row", out_row, exp_orow);
      chk("out_col", out_col, exp_ocol);
    end
    if (en) en_cnt++;
    if (win_valid) wv_cnt++;
    if (spec_img && exp_wv && !first_seen) begin
      first_seen = 1'b1;
      chk("first_row", out_row, 0);
      chk("first_col", out_col, 0);
      chk("first_in01", got[0][0], 4);
      chk("first_in05", got[0][4], 60);
      chk("first_in25", got[2][4], 62);
    end
  endtask

  // called at a negedge: drive, advance model, check at next negedge
  task automatic step(bit v, bit s);
    bit acc;
    bit s_eff;
    int r;
    int c;
    s_eff    = s && !busy && !exp_fd;
    acc      = v && busy;
    start    = s;
    in_valid = v;
    if (busy) begin
      r = nbeat / W;
      c = nbeat % W;
      in_data = {8'(img[r][c][2]), 8'(img[r][c][1]), 8'(img[r][c][0])};
    end else begin
      in_data = 24'($urandom);
    end
    exp_en = 1'b0;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    if (acc) begin
      r = nbeat / W;
      c = nbeat % W;
      if (r >= 4) begin
        exp_en = 1'b1;
        for (int x = 0; x < 3; x++)
          for (int j = 0; j < 5; j++)
            exp_col[x][j] = img[r - 4 + j][c][x];
        exp_wv = (c >= 4);
        if (c >= 4) begin
          exp_orow = r - 4;
          exp_ocol = c - 4;
        end
      end
      nbeat++;
      if (nbeat == H * W) begin
        busy   = 1'b0;
        exp_fd = 1'b1;
        nbeat  = 0;
      end
    end
    if (s_eff) begin
      busy  = 1'b1;
      nbeat = 0;
    end
    @(negedge clk);
    check_outs(1'b0);
  endtask

  task automatic do_reset(int n);
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    clear_model();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_outs(1'b1);
    end
    rst = 1'b0;
  endtask

  task automatic run_frame(bit rndv, bit formula, int abort_at, int start_at);
    bit v;
    bit s;
    fill_img(formula);
    spec_img   = formula;
    first_seen = 1'b0;
    en_cnt     = 0;
    wv_cnt     = 0;
    step(1'b0, 1'b1);
    for (int k = 0; k < 4000 && busy; k++) begin
      if (abort_at >= 0 && nbeat == abort_at) begin
        do_reset(3);
        return;
      end
      s = (start_at >= 0 && nbeat == start_at);
      v = rndv ? bit'($urandom_range(1)) : 1'b1;
      step(v, s);
    end
    chk("frame_timeout", busy, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("en_total", en_cnt, 140);
    chk("wv_total", wv_cnt, 100);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    spec_img = 1'b0;
    en_cnt   = 0;
    wv_cnt   = 0;
    clear_model();
    @(negedge clk);
    do_reset(4);

    for (int k = 0; k < 20; k++)
      step(1'b1, 1'b0);

    run_frame(1'b0, 1'b1, -1, -1);
    run_frame(1'b1, 1'b1, -1, -1);
    run_frame(1'b1, 1'b1, 7 * W + 3, -1);
    run_frame(1'b0, 1'b1, -1, -1);
    run_frame(1'b1, 1'b1, -1, 6 * W + 2);
    run_frame(1'b1, 1'b0, -1, -1);
    run_frame(1'b0, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
